// File: rtl/ifmap_spad_ctrl.sv
// Ifmap scratchpad controller: fills a 16x8 window from upstream, then
// replays it to the MAC a configurable number of passes.
module ifmap_spad_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] cfg_len,
    input  logic [3:0] cfg_reps,
    input  logic       load_start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       stream_start,
    output logic       spad_wr,
    output logic       spad_rd,
    output logic [3:0] spad_addr,
    output logic [7:0] spad_wdata,
    input  logic [7:0] spad_rdata,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LOADED,
        STREAM
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [4:0] len_q;
    logic [3:0] reps_q;
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [3:0] pass_cnt;
    logic       cfg_ok;
    logic       load_go;
    logic       stream_go;
    logic       wr_last;
    logic       rd_last;
    logic       rd_wrap;

    assign cfg_ok   = (cfg_len != 5'd0) && (cfg_len <= 5'd16);
    assign rd_wrap  = ({1'b0, rd_ptr} == len_q - 5'd1);
    assign out_data = spad_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        spad_wr    = 1'b0;
        spad_rd    = 1'b0;
        spad_addr  = 4'd0;
        spad_wdata = 8'd0;
        busy       = 1'b0;
        load_go    = 1'b0;
        stream_go  = 1'b0;
        wr_last    = 1'b0;
        rd_last    = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start && cfg_ok) begin
                    load_go  = 1'b1;
                    state_nx = FILL;
                end
            end
            FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    spad_wr    = 1'b1;
                    spad_addr  = wr_ptr;
                    spad_wdata = in_data;
                    if ({1'b0, wr_ptr} == len_q - 5'd1) begin
                        wr_last  = 1'b1;
                        state_nx = LOADED;
                    end
                end
            end
            LOADED: begin
                // a new fill takes precedence over a replay request
                if (load_start && cfg_ok) begin
                    load_go  = 1'b1;
                    state_nx = FILL;
                end else if (stream_start) begin
                    stream_go = 1'b1;
                    state_nx  = STREAM;
                end
            end
            STREAM: begin
                busy      = 1'b1;
                spad_rd   = 1'b1;
                spad_addr = rd_ptr;
                if (rd_wrap && (pass_cnt == reps_q)) begin
                    rd_last  = 1'b1;
                    state_nx = LOADED;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= 5'd0;
            reps_q    <= 4'd0;
            wr_ptr    <= 4'd0;
            rd_ptr    <= 4'd0;
            pass_cnt  <= 4'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= spad_rd;
            out_last  <= rd_last;
            done      <= wr_last | rd_last;
            if (load_go) begin
                len_q  <= cfg_len;
                wr_ptr <= 4'd0;
            end else if (spad_wr) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (stream_go) begin
                reps_q   <= cfg_reps;
                rd_ptr   <= 4'd0;
                pass_cnt <= 4'd0;
            end else if (spad_rd) begin
                if (rd_wrap) begin
                    rd_ptr   <= 4'd0;
                    pass_cnt <= pass_cnt + 4'd1;
                end else begin
                    rd_ptr <= rd_ptr + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// Scoreboard bench for ifmap_spad_ctrl with a behavioural scratchpad and
// a window/pass reference model.
module tb_ifmap_spad_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] cfg_len = 5'd0;
    logic [3:0] cfg_reps = 4'd0;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       stream_start = 1'b0;
    logic       spad_wr;
    logic       spad_rd;
    logic [3:0] spad_addr;
    logic [7:0] spad_wdata;
    logic [7:0] spad_rdata = 8'd0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    ifmap_spad_ctrl dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_reps(cfg_reps),
        .load_start(load_start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stream_start(stream_start),
        .spad_wr(spad_wr), .spad_rd(spad_rd), .spad_addr(spad_addr),
        .spad_wdata(spad_wdata), .spad_rdata(spad_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (spad_wr) mem[spad_addr] <= spad_wdata;
        if (spad_rd) spad_rdata <= mem[spad_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int compared = 0;
    int mismatched = 0;
    logic [8:0]  sbq[$];
    logic [11:0] wq[$];
    logic [7:0]  ref_mem [16];
    int  model_len = 0;
    bit  model_loaded = 0;
    bit  mon_en = 0;
    bit  fill_win = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [8:0]  e;
            logic [11:0] w;
            chk("wr_rd_excl", 32'(spad_wr & spad_rd), 0);
            if (!spad_wr && !spad_rd)
                chk("addr_idle", {20'd0, spad_addr, spad_wdata}, 0);
            if (spad_wr) begin
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("spad_write", {20'd0, spad_addr, spad_wdata},
                        {20'd0, w});
                end else begin
                    chk("wr_unexp", 32'(spad_wr), 0);
                end
            end
            if (out_valid) begin
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[7:0]));
                    chk("out_last", 32'(out_last), 32'(e[8]));
                    chk("done_last", 32'(done), 32'(e[8]));
                end else begin
                    chk("out_unexp", 32'(out_valid), 0);
                end
            end else begin
                chk("last_novalid", 32'(out_last), 0);
                if (!fill_win) chk("spur_done", 32'(done), 0);
            end
        end
    end

    task automatic fill(input int len, input bit toggle, input bit rgap,
                        input bit fixed, input bit sim);
        int c0;
        int clast;
        logic [7:0] d;
        @(posedge clk); #1;
        load_start = 1'b1;
        cfg_len = 5'(len);
        stream_start = sim;
        @(posedge clk); #1;
        load_start = 1'b0;
        stream_start = 1'b0;
        c0 = cyc;
        clast = cyc;
        chk("fill_in_ready", 32'(in_ready), 1);
        chk("fill_no_rd", 32'(spad_rd), 0);
        model_loaded = 0;
        for (int i = 0; i < len; i++) begin
            if (toggle && i > 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else if (rgap) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            d = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            ref_mem[i] = d;
            wq.push_back({4'(i), d});
            in_valid = 1'b1;
            in_data = d;
            clast = cyc;
            if (i == len - 1) fill_win = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("fill_done", 32'(done), 1);
        chk("fill_busy", 32'(busy), 0);
        chk("fill_in_ready_off", 32'(in_ready), 0);
        chk("fill_wq_empty", wq.size(), 0);
        if (toggle) chk("fill_span", clast - c0 + 1, 2 * len - 1);
        fill_win = 0;
        model_len = len;
        model_loaded = 1;
    endtask

    task automatic stream(input int reps);
        int t0;
        int n;
        int exp_n;
        bit seen;
        @(posedge clk); #1;
        cfg_reps = 4'(reps);
        stream_start = 1'b1;
        t0 = cyc;
        exp_n = 0;
        if (model_loaded) begin
            exp_n = model_len * (reps + 1);
            for (int p = 0; p <= reps; p++)
                for (int a = 0; a < model_len; a++)
                    sbq.push_back({(p == reps && a == model_len - 1),
                                   ref_mem[a]});
        end
        @(posedge clk); #1;
        stream_start = 1'b0;
        if (exp_n > 0) begin
            seen = 0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk); #1;
                if (out_valid) seen = 1;
            end
            chk("first_latency", seen ? cyc - t0 : 99, 2);
            n = seen ? 1 : 0;
            while (seen && !out_last && n <= exp_n + 2) begin
                @(negedge clk); #1;
                if (!out_valid) break;
                n++;
            end
            chk("burst_len", n, exp_n);
            @(negedge clk); #1;
            chk("stream_end_busy", 32'(busy), 0);
            chk("stream_end_valid", 32'(out_valid), 0);
            chk("sbq_empty", sbq.size(), 0);
        end else begin
            repeat (6) @(negedge clk);
            #1;
            chk("nostream_busy", 32'(busy), 0);
        end
    endtask

    task automatic bad_load(input int len);
        @(posedge clk); #1;
        load_start = 1'b1;
        cfg_len = 5'(len);
        @(posedge clk); #1;
        load_start = 1'b0;
        @(negedge clk);
        chk("bad_len_ready", 32'(in_ready), 0);
        chk("bad_len_busy", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_spad", {30'd0, spad_wr, spad_rd}, 0);
        mon_en = 1;

        bad_load(0);
        bad_load(17);
        stream(3);

        fill(4, 0, 0, 1, 0);
        stream(1);
        fill(16, 1, 0, 0, 0);
        stream(0);
        fill(5, 0, 0, 0, 1);
        bad_load(0);
        bad_load(17);
        stream(2);
        fill(1, 0, 0, 0, 0);
        stream(0);
        stream(15);

        for (int it = 0; it < 20; it++) begin
            fill($urandom_range(1, 16), 0, 1, 0, 0);
            repeat ($urandom_range(1, 2)) stream($urandom_range(0, 3));
        end

        fill(6, 0, 0, 0, 0);
        begin
            int t0;
            @(posedge clk); #1;
            cfg_reps = 4'd3;
            stream_start = 1'b1;
            t0 = cyc;
            for (int p = 0; p <= 3; p++)
                for (int a = 0; a < 6; a++)
                    sbq.push_back({(p == 3 && a == 5), ref_mem[a]});
            @(posedge clk); #1;
            stream_start = 1'b0;
            while (cyc < t0 + 3) begin
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            sbq.delete();
            model_loaded = 0;
            @(negedge clk);
            chk("abort_valid", 32'(out_valid), 0);
            chk("abort_last", 32'(out_last), 0);
            chk("abort_done", 32'(done), 0);
            chk("abort_busy", 32'(busy), 0);
            chk("abort_spad", {30'd0, spad_wr, spad_rd}, 0);
        end
        stream(1);
        fill(3, 0, 1, 0, 0);
        stream(1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
